// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared definitions for the sequential binary-to-BCD converter:
//            FSM state type and encodings, default digit count, and the
//            saturation helper functions used by the converter top level.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

   // FSM state type; explicit one-bit width keeps it legacy-compatible
   typedef logic [0:0] state_t;

   localparam state_t IDLE  = 1'b0;
   localparam state_t SHIFT = 1'b1;

   // Default number of BCD digits on the display path
   localparam int DEF_N_DIGITS = 8;

   // Largest binary value that still fits in n_digits decimal digits
   // (10^n_digits - 1). Valid for n_digits up to 19 in 64 bits.
   function automatic logic [63:0] sat_bin(input int n_digits);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n_digits; i++) begin
         p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

   // Packed BCD word with the low n_digits nibbles all set to 9; callers
   // slice out the 4*n_digits bits they need.
   function automatic logic [255:0] sat_bcd(input int n_digits);
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < n_digits) begin
            r[4*i +: 4] = 4'h9;
         end
      end
      return r;
   endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_adj
// Purpose  : Double-dabble nibble correction. Adds 3 to a BCD digit that is
//            5 or more so that the following left shift carries correctly
//            into the next decimal digit.
// Ports    : digit_i  in  4  current BCD digit (always 0..9)
//            digit_o  out 4  corrected digit
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   // Input never exceeds 9, so the 4-bit sum never carries out (max 12)
   always_comb begin
      digit_o = digit_i;
      if (digit_i >= 4'd5) begin
         digit_o = digit_i + 4'd3;
      end
   end

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Purpose  : Iterative double-dabble binary-to-BCD converter, one input bit
//            per clock. Accepts a value over valid/ready, produces the packed
//            BCD result (digit 0 in bits [3:0]) with a one-cycle done pulse.
//            Values that do not fit in N_DIGITS decimal digits saturate to
//            all nines and raise ovf_o.
// Ports    : clk         in  1           system clock, rising edge
//            rst         in  1           synchronous active-high reset
//            bin_i       in  N_BITS      unsigned value to convert
//            in_valid_i  in  1           bin_i is valid
//            in_ready_o  out 1           idle, can accept a value
//            bcd_o       out 4*N_DIGITS  registered BCD result
//            done_o      out 1           one-cycle pulse when bcd_o updates
//            ovf_o       out 1           last conversion saturated
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int N_BITS   = 32,
   parameter int N_DIGITS = DEF_N_DIGITS
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_BITS-1:0]       bin_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   output logic [4*N_DIGITS-1:0]   bcd_o,
   output logic                    done_o,
   output logic                    ovf_o
);

   localparam int BCD_W = 4 * N_DIGITS;
   localparam int CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

   // Comparison width: wide enough for both the input and the 64-bit
   // saturation constant, so the compare is a true unsigned magnitude test.
   localparam int CMP_W = (N_BITS > 64) ? N_BITS : 64;

   localparam logic [CMP_W-1:0] SAT_BIN     = CMP_W'(sat_bin(N_DIGITS));
   localparam logic [255:0]     SAT_BCD_ALL = sat_bcd(N_DIGITS);
   localparam logic [BCD_W-1:0] SAT_BCD     = SAT_BCD_ALL[BCD_W-1:0];
   localparam logic [CNT_W-1:0] LAST_ITER   = CNT_W'(N_BITS - 1);

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   state_t              state_q,    state_d;
   logic [N_BITS-1:0]   bin_sr_q,   bin_sr_d;
   logic [BCD_W-1:0]    bcd_sr_q,   bcd_sr_d;
   logic [CNT_W-1:0]    cnt_q,      cnt_d;
   logic                ovf_pend_q, ovf_pend_d;
   logic [BCD_W-1:0]    bcd_q,      bcd_d;
   logic                done_q,     done_d;
   logic                ovf_q,      ovf_d;

   // ---------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------
   logic [BCD_W-1:0]        adj_w;
   logic [BCD_W+N_BITS-1:0] shift_w;
   logic [CMP_W-1:0]        bin_ext_w;
   logic                    ovf_w;
   logic                    accept_w;

   // Per-digit +3 correction on the current BCD accumulator
   for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit_adj
      bcd_digit_adj u_adj (
         .digit_i (bcd_sr_q[4*g +: 4]),
         .digit_o (adj_w[4*g +: 4])
      );
   end

   // Corrected digits and remaining binary bits shift left as one word;
   // the MSB of the corrected BCD falls off (it is always 0 for legal data).
   assign shift_w = {adj_w, bin_sr_q} << 1;

   assign bin_ext_w = CMP_W'(bin_i);
   assign ovf_w     = (bin_ext_w > SAT_BIN);

   assign in_ready_o = (state_q == IDLE);
   assign accept_w   = in_valid_i && in_ready_o;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      bin_sr_d   = bin_sr_q;
      bcd_sr_d   = bcd_sr_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      bcd_d      = bcd_q;
      done_d     = 1'b0;
      ovf_d      = ovf_q;

      case (state_q)
         IDLE: begin
            if (accept_w) begin
               bin_sr_d   = bin_i;
               bcd_sr_d   = '0;
               cnt_d      = '0;
               ovf_pend_d = ovf_w;
               state_d    = SHIFT;
            end
         end

         SHIFT: begin
            bcd_sr_d = shift_w[BCD_W+N_BITS-1 : N_BITS];
            bin_sr_d = shift_w[N_BITS-1:0];
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               // Publish straight from the final shift so bcd_o never
               // exposes a partial accumulator.
               bcd_d   = ovf_pend_q ? SAT_BCD : shift_w[BCD_W+N_BITS-1 : N_BITS];
               done_d  = 1'b1;
               ovf_d   = ovf_pend_q;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         bin_sr_q   <= '0;
         bcd_sr_q   <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         bcd_q      <= '0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_sr_q   <= bin_sr_d;
         bcd_sr_q   <= bcd_sr_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         bcd_q      <= bcd_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
      end
   end

   assign bcd_o  = bcd_q;
   assign done_o = done_q;
   assign ovf_o  = ovf_q;

endmodule : bin_to_bcd_seq
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_seq
// Purpose  : Self-checking bench for bin_to_bcd_seq. Directed scenarios plus
//            a randomized sweep compared against a decimal reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] bin_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] bcd_o;
   logic        done_o;
   logic        ovf_o;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.N_BITS(32), .N_DIGITS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .bin_i      (bin_i),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .bcd_o      (bcd_o),
      .done_o     (done_o),
      .ovf_o      (ovf_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Decimal reference: plain base-10 digit extraction, saturating above
   // 99,999,999.
   task automatic ref_model(input logic [31:0] v, output logic [31:0] b, output logic o);
      longint unsigned t;
      b = '0;
      o = 1'b0;
      if (v > 32'd99999999) begin
         b = 32'h99999999;
         o = 1'b1;
      end else begin
         t = longint'(v);
         for (int i = 0; i < 8; i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present v (caller is 1 time unit after an edge, DUT expected idle),
   // then follow the conversion to its done cycle.
   task automatic do_conv(input logic [31:0] v, input string tag, input bit chk_hold);
      logic [31:0] exp_b;
      logic        exp_o;
      logic [31:0] prev;
      bit          hold_ok;
      bit          busy_ok;
      int          k;
      ref_model(v, exp_b, exp_o);
      check({tag, "_ready"}, 64'(in_ready_o), 64'd1);
      prev       = bcd_o;
      bin_i      = v;
      in_valid_i = 1'b1;
      step();
      in_valid_i = 1'b0;
      k       = 0;
      hold_ok = 1'b1;
      busy_ok = 1'b1;
      while (done_o !== 1'b1 && k < 40) begin
         if (bcd_o !== prev) hold_ok = 1'b0;
         if (in_ready_o !== 1'b0) busy_ok = 1'b0;
         step();
         k++;
      end
      check({tag, "_latency"}, 64'(k), 64'd32);
      check({tag, "_bcd"}, 64'(bcd_o), 64'(exp_b));
      check({tag, "_ovf"}, 64'(ovf_o), 64'(exp_o));
      if (chk_hold) begin
         check({tag, "_hold"}, 64'(hold_ok), 64'd1);
         check({tag, "_busy"}, 64'(busy_ok), 64'd1);
         check({tag, "_idle_at_done"}, 64'(in_ready_o), 64'd1);
      end
   endtask

   initial begin
      logic [31:0] v;
      bit          no_done;
      int          k;

      rst        = 1'b1;
      bin_i      = '0;
      in_valid_i = 1'b0;
      step();
      step();
      check("reset_bcd", 64'(bcd_o), 64'd0);
      check("reset_done", 64'(done_o), 64'd0);
      check("reset_ovf", 64'(ovf_o), 64'd0);
      check("reset_ready", 64'(in_ready_o), 64'd1);
      rst = 1'b0;
      step();

      // Zero, with the done pulse width checked
      do_conv(32'd0, "zero", 1'b1);
      check("zero_done", 64'(done_o), 64'd1);
      step();
      check("zero_done_pulse", 64'(done_o), 64'd0);

      do_conv(32'd12345678, "d12345678", 1'b1);
      step();
      do_conv(32'd99999999, "max_fit", 1'b1);
      step();
      do_conv(32'd100000000, "first_sat", 1'b1);
      step();
      do_conv(32'hFFFFFFFF, "all_ones", 1'b1);
      step();

      // Valid during a conversion is ignored
      bin_i      = 32'd42;
      in_valid_i = 1'b1;
      step();
      in_valid_i = 1'b0;
      for (int i = 0; i < 10; i++) step();
      bin_i      = 32'd777;
      in_valid_i = 1'b1;
      step();
      in_valid_i = 1'b0;
      k = 11;
      while (done_o !== 1'b1 && k < 40) begin
         step();
         k++;
      end
      check("ignore_latency", 64'(k), 64'd32);
      check("ignore_bcd", 64'(bcd_o), 64'h42);
      check("ignore_ovf", 64'(ovf_o), 64'd0);
      // Back-to-back: 777 presented in the done cycle
      do_conv(32'd777, "b2b", 1'b1);

      // Reset mid-conversion
      step();
      bin_i      = 32'd55555555;
      in_valid_i = 1'b1;
      step();
      in_valid_i = 1'b0;
      for (int i = 0; i < 15; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_bcd", 64'(bcd_o), 64'd0);
      check("abort_done", 64'(done_o), 64'd0);
      check("abort_ready", 64'(in_ready_o), 64'd1);
      check("abort_ovf", 64'(ovf_o), 64'd0);
      no_done = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (done_o !== 1'b0) no_done = 1'b0;
         step();
      end
      check("abort_no_done", 64'(no_done), 64'd1);
      do_conv(32'd10, "after_abort", 1'b1);

      // Randomized sweep, back-to-back; half the values inside the
      // representable range so the digit path is exercised, not just
      // saturation.
      for (int i = 0; i < 1000; i++) begin
         if (i % 2 == 0) v = $urandom_range(99999999, 0);
         else            v = $urandom;
         do_conv(v, "rand", 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_bin_to_bcd_seq
`default_nettype wire
